axi_rb_responder: RTL and testbench
===================================

Name: axi_rb_responder

Overview:
- AXI4 read-burst responder (slave end) for the AXI read initiators generated by the HLS flow.
- Accepts one AR request at a time and fetches each beat from a single-port, 1-cycle-latency word RAM.
- Streams the beats back on the R channel with RRESP/RLAST.
- Used as the memory model and bench partner for generated read kernels, and as on-chip memory behind them.

Parameters:
ADDR_WIDTH, 16, byte address width of araddr
DATA_WIDTH, 32, R data width; power of two, 8..128
MEM_AW, 8, word address width of the backing RAM; RAM holds 2^MEM_AW words

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
s_axi_araddr  in  ADDR_WIDTH  burst start byte address
s_axi_arburst  in  2  0 FIXED, 1 INCR, 2 WRAP, 3 reserved
s_axi_arlen  in  8  beats minus one
s_axi_arsize  in  3  log2 bytes per beat
s_axi_arvalid  in  1  AR valid
s_axi_arready  out  1  AR ready
s_axi_rdata  out  DATA_WIDTH  beat data
s_axi_rresp  out  2  0 OKAY, 2 SLVERR
s_axi_rlast  out  1  final beat of burst
s_axi_rvalid  out  1  R valid
s_axi_rready  in  1  R ready
mem_raddr  out  MEM_AW  RAM word address
mem_ren  out  1  RAM read enable
mem_rdata  in  DATA_WIDTH  RAM data, valid the cycle after mem_ren
stat_bursts  out  32  completed burst count (optional feature)
stat_beats  out  32  completed beat count (optional feature)

Behaviour:
- Clocking and reset: one clock `clk`; `rst` is asynchronous and active-high.
- Reset values: state IDLE, arready=1, rvalid=0, rlast=0, rresp=0, rdata=0, mem_ren=0, mem_raddr=0, stat counters=0.
- Reset mid-burst: rvalid drops immediately (asynchronously); the burst is abandoned and no beats resume after reset.
- FSM states: IDLE, ADDR, WAIT, DATA.
- IDLE: arready=1. On arvalid&arready, latch addr, len, size, burst; clear beat counter; go to ADDR. arready is 0 in all other states.
- ADDR: mem_ren=1 only if the beat is in range; mem_raddr = addr >> log2(DATA_WIDTH/8), truncated to MEM_AW. Go to WAIT.
- WAIT: capture mem_rdata into the rdata register, or 0 for an error beat. Go to DATA.
- DATA: rvalid=1; rdata, rresp and rlast are held stable until rready.
  - On rvalid&rready with the last beat: go to IDLE.
  - Otherwise: advance the address, increment the beat counter, go to ADDR.
- Latency and throughput: AR handshake in cycle 0 gives first rvalid in cycle 3. Peak rate is one beat per 3 cycles. A new AR can be accepted in the cycle after the last R handshake.
- rlast=1 exactly when beat counter == len.
- Address advance, per beat:
  - FIXED: unchanged.
  - INCR: addr + (1<<size), wrapping modulo 2^ADDR_WIDTH.
  - WRAP: boundary = (len+1)<<size; the address wraps within the aligned block of that size.
- Errors: rresp=SLVERR for every beat of the burst, rdata=0, no RAM read, but all len+1 beats are still returned, when any of the following hold:
  - size > log2(DATA_WIDTH/8);
  - burst==3;
  - WRAP with len not in {1,3,7,15};
  - WRAP with an unaligned start address.
- Out-of-range beat: byte addr >= 2^MEM_AW * DATA_WIDTH/8 gives SLVERR with rdata=0 for that beat only.
- Narrow beats: the full RAM word is returned with no lane steering.
- arvalid asserted while busy is ignored until IDLE.
- len=255 INCR gives exactly 256 beats.

Optional Feature:
- Macro: AXI_RB_RESPONDER_STATS_EN.
- Defined:
  - stat_beats increments on every R handshake.
  - stat_bursts increments on every R handshake with rlast.
  - Both counters wrap at 2^32 and reset to 0.
- Undefined: both ports are tied to 0 and no counter registers are built.

Test Plan:
- RAM word i = 0x1000+i. AR INCR addr=0x0010, len=3, size=2, rready=1 -> rdata 0x1004,0x1005,0x1006,0x1007, rresp=0, rlast only on the 4th beat, first rvalid 3 cycles after AR handshake.
- WRAP addr=0x0018, len=3, size=2 -> words 6,7,4,5. WRAP len=2 -> 3 beats of SLVERR, rdata=0, mem_ren never asserted.
- FIXED addr=0x0008, len=2 -> three beats of 0x1002. size=3 with DATA_WIDTH=32 -> SLVERR on every beat.
- rready held 0 for 5 cycles during beat 1 of an INCR len=1 burst -> rvalid, rdata and rlast stable throughout; beat delivered once rready rises; arready stays 0.
- INCR crossing RAM end (MEM_AW=8, addr=0x03FC, len=1) -> beat0 OKAY 0x10FF, beat1 SLVERR 0.
- rst pulsed during beat 2 of len=7 -> rvalid 0 immediately, arready 1 after release; with macro, two full len=3 bursts give stat_beats=8, stat_bursts=2.

Source files
------------

// File: rtl/axi_rb_responder_if.sv
// AXI4 read-address / read-data channel bundle for axi_rb_responder.
// The responder uses the slave modport; a read initiator or bench uses master.
interface axi_rb_responder_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] araddr;
  logic [1:0]            arburst;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output araddr, arburst, arlen, arsize, arvalid, rready,
    input  arready, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  araddr, arburst, arlen, arsize, arvalid, rready,
    output arready, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_rb_responder.sv
// AXI4 read-burst responder backed by a single-port, 1-cycle-latency word RAM.
// Optional beat/burst statistics are built when AXI_RB_RESPONDER_STATS_EN is defined.
//
// state | meaning
// IDLE  | arready high, waiting for an AR request
// ADDR  | present word address to the RAM (read skipped for error beats)
// WAIT  | RAM data returns; capture it (or 0) with the beat response
// DATA  | rvalid high, beat held until rready
module axi_rb_responder #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_AW     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  axi_rb_responder_if.slave     s_axi,
  output logic [MEM_AW-1:0]     mem_raddr,
  output logic                  mem_ren,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [31:0]           stat_bursts,
  output logic [31:0]           stat_beats
);

  localparam int         LG_BYTES = $clog2(DATA_WIDTH / 8);
  localparam logic [2:0] LG_SIZE  = 3'(LG_BYTES);
  localparam int         HI_BIT   = MEM_AW + LG_BYTES;
  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  typedef enum logic [1:0] {IDLE, ADDR, WAIT, DATA} state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic [7:0]            beat_q;
  logic                  burst_err_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;

  logic                  ar_take, capture, beat_adv;
  logic                  ar_err, last_beat, beat_oob, beat_err;
  logic [ADDR_WIDTH-1:0] step, incr_addr, wrap_mask, next_addr;

  // Whole-burst errors are decided once, at AR acceptance.
  always_comb begin
    ar_err = 1'b0;
    if (s_axi.arsize > LG_SIZE)
      ar_err = 1'b1;
    if (s_axi.arburst == 2'd3)
      ar_err = 1'b1;
    if (s_axi.arburst == BURST_WRAP) begin
      if (!(s_axi.arlen inside {8'd1, 8'd3, 8'd7, 8'd15}))
        ar_err = 1'b1;
      if (|(s_axi.araddr & ((ADDR_WIDTH'(1) << s_axi.arsize) - ADDR_WIDTH'(1))))
        ar_err = 1'b1;
    end
  end

  generate
    if (ADDR_WIDTH > HI_BIT) begin : g_oob
      assign beat_oob = |addr_q[ADDR_WIDTH-1:HI_BIT];
    end else begin : g_no_oob
      assign beat_oob = 1'b0;
    end
  endgenerate

  assign beat_err  = burst_err_q | beat_oob;
  assign last_beat = (beat_q == len_q);

  // WRAP keeps the upper address bits of the aligned (len+1)<<size block.
  always_comb begin
    step      = ADDR_WIDTH'(1) << size_q;
    incr_addr = addr_q + step;
    wrap_mask = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);
    case (burst_q)
      BURST_FIXED: next_addr = addr_q;
      BURST_WRAP:  next_addr = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
      default:     next_addr = incr_addr;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    s_axi.arready  = 1'b0;
    s_axi.rvalid   = 1'b0;
    mem_ren        = 1'b0;
    mem_raddr      = '0;
    ar_take        = 1'b0;
    capture        = 1'b0;
    beat_adv       = 1'b0;
    case (state_q)
      IDLE: begin
        s_axi.arready = 1'b1;
        if (s_axi.arvalid) begin
          ar_take = 1'b1;
          state_d = ADDR;
        end
      end
      ADDR: begin
        mem_ren   = ~beat_err;
        mem_raddr = MEM_AW'(addr_q >> LG_BYTES);
        state_d   = WAIT;
      end
      WAIT: begin
        capture = 1'b1;
        state_d = DATA;
      end
      DATA: begin
        s_axi.rvalid = 1'b1;
        if (s_axi.rready) begin
          if (last_beat) begin
            state_d = IDLE;
          end else begin
            beat_adv = 1'b1;
            state_d  = ADDR;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      beat_q      <= '0;
      burst_err_q <= 1'b0;
      rdata_q     <= '0;
      rresp_q     <= RESP_OKAY;
    end else begin
      if (ar_take) begin
        addr_q      <= s_axi.araddr;
        len_q       <= s_axi.arlen;
        size_q      <= s_axi.arsize;
        burst_q     <= s_axi.arburst;
        beat_q      <= '0;
        burst_err_q <= ar_err;
      end
      if (capture) begin
        rdata_q <= beat_err ? '0 : mem_rdata;
        rresp_q <= beat_err ? RESP_SLVERR : RESP_OKAY;
      end
      if (beat_adv) begin
        addr_q <= next_addr;
        beat_q <= beat_q + 8'd1;
      end
    end
  end

  assign s_axi.rdata = rdata_q;
  assign s_axi.rresp = rresp_q;
  assign s_axi.rlast = (state_q == DATA) && last_beat;

`ifdef AXI_RB_RESPONDER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_beats  <= '0;
      stat_bursts <= '0;
    end else if (s_axi.rvalid && s_axi.rready) begin
      stat_beats <= stat_beats + 32'd1;
      if (s_axi.rlast)
        stat_bursts <= stat_bursts + 32'd1;
    end
  end
`else
  assign stat_beats  = '0;
  assign stat_bursts = '0;
`endif

endmodule

// File: tb/tb_axi_rb_responder.sv
// Randomised bench for axi_rb_responder against a per-beat address/response model.
module tb_axi_rb_responder;
  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int MAW = 8;
  localparam int MEM_BYTES = (1 << MAW) * (DW / 8);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [MAW-1:0] mem_raddr;
  logic           mem_ren;
  logic [DW-1:0]  mem_rdata = '0;
  logic [31:0]    stat_bursts;
  logic [31:0]    stat_beats;

  axi_rb_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_axi ();

  axi_rb_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_AW(MAW)) dut (
    .clk         (clk),
    .rst         (rst),
    .s_axi       (s_axi),
    .mem_raddr   (mem_raddr),
    .mem_ren     (mem_ren),
    .mem_rdata   (mem_rdata),
    .stat_bursts (stat_bursts),
    .stat_beats  (stat_beats)
  );

  always #5 clk = ~clk;

  logic [31:0] ram [0:255];
  int          ren_cnt = 0;

  always @(posedge clk) begin
    if (mem_ren) begin
      mem_rdata <= ram[mem_raddr];
      ren_cnt   <= ren_cnt + 1;
    end
  end

  int n_chk  = 0;
  int n_fail = 0;
  int exp_beats  = 0;
  int exp_bursts = 0;

  logic [31:0] exp_data [$];
  logic [1:0]  exp_resp [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Beat i of a burst: its byte address from the AXI burst rules, then range/error.
  task automatic model_burst(input int addr, input int burst, input int len, input int size);
    int  bytes;
    bit  err;
    exp_data.delete();
    exp_resp.delete();
    bytes = 1 << size;
    err   = (size > 2) || (burst == 3);
    if (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) err = 1'b1;
    if (burst == 2 && (addr % bytes) != 0) err = 1'b1;
    for (int i = 0; i <= len; i++) begin
      int a;
      int wrap;
      int base;
      bit bad;
      a = 0;
      if (!err) begin
        case (burst)
          0: a = addr;
          1: a = (addr + i * bytes) % 65536;
          default: begin
            wrap = (len + 1) * bytes;
            base = addr - (addr % wrap);
            a    = base + ((addr - base + i * bytes) % wrap);
          end
        endcase
      end
      bad = err || (a >= MEM_BYTES);
      exp_data.push_back(bad ? 32'd0 : ram[a / 4]);
      exp_resp.push_back(bad ? 2'd2 : 2'd0);
    end
  endtask

  task automatic do_reset_pulse();
    rst = 1'b1;
    #1;
    check("rst_rvalid_async", {31'd0, s_axi.rvalid}, 32'd0);
    s_axi.arvalid = 1'b0;
    s_axi.rready  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_beats  = 0;
    exp_bursts = 0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_rvalid", {31'd0, s_axi.rvalid}, 32'd0);
    end
    check("post_rst_arready", {31'd0, s_axi.arready}, 32'd1);
  endtask

  // Issues one AR and collects its beats. stall_beat/stall_n force rready low;
  // abort_at >= 0 pulses reset while that beat is being presented.
  task automatic run_burst(input int addr, input int burst, input int len, input int size,
                           input int stall_pct, input bit junk_ar,
                           input int stall_beat, input int stall_n, input int abort_at);
    int n_ok;
    int ren0;
    int cyc;
    int k;
    int stalled;
    int budget;
    bit first;
    bit hs;
    model_burst(addr, burst, len, size);
    n_ok = 0;
    foreach (exp_resp[i]) if (exp_resp[i] == 2'd0) n_ok++;
    @(negedge clk);
    s_axi.araddr  = AW'(addr);
    s_axi.arburst = 2'(burst);
    s_axi.arlen   = 8'(len);
    s_axi.arsize  = 3'(size);
    s_axi.arvalid = 1'b1;
    s_axi.rready  = 1'b0;
    check("arready_before_ar", {31'd0, s_axi.arready}, 32'd1);
    ren0 = ren_cnt;
    @(posedge clk);
    @(negedge clk);
    if (junk_ar) begin
      s_axi.araddr  = AW'($urandom);
      s_axi.arlen   = 8'($urandom);
      s_axi.arburst = 2'd1;
      s_axi.arsize  = 3'd0;
    end else begin
      s_axi.arvalid = 1'b0;
    end
    cyc     = 1;
    k       = 0;
    stalled = 0;
    first   = 1'b1;
    budget  = 10 * (len + 1) + 20;
    while (k <= len) begin
      if (cyc > budget) begin
        check("burst_timeout", 32'(k), 32'(len + 1));
        break;
      end
      check("arready_busy", {31'd0, s_axi.arready}, 32'd0);
      hs = 1'b0;
      if (s_axi.rvalid) begin
        if (first) begin
          check("first_rvalid_latency", 32'(cyc), 32'd3);
          first = 1'b0;
        end
        check("rdata", s_axi.rdata, exp_data[k]);
        check("rresp", {30'd0, s_axi.rresp}, {30'd0, exp_resp[k]});
        check("rlast", {31'd0, s_axi.rlast}, (k == len) ? 32'd1 : 32'd0);
        if (k == abort_at) begin
          do_reset_pulse();
          return;
        end
        if (k == stall_beat && stalled < stall_n) begin
          s_axi.rready = 1'b0;
          stalled++;
        end else begin
          s_axi.rready = ($urandom_range(99) >= stall_pct);
        end
        hs = s_axi.rready;
      end else begin
        check("rlast_idle", {31'd0, s_axi.rlast}, 32'd0);
        s_axi.rready = $urandom_range(1);
      end
      @(posedge clk);
      if (hs) begin
        k++;
        exp_beats++;
        if (k > len) exp_bursts++;
      end
      @(negedge clk);
      cyc++;
    end
    s_axi.arvalid = 1'b0;
    s_axi.rready  = 1'b0;
    check("arready_after_burst", {31'd0, s_axi.arready}, 32'd1);
    check("rvalid_after_burst", {31'd0, s_axi.rvalid}, 32'd0);
    check("mem_ren_count", 32'(ren_cnt - ren0), 32'(n_ok));
  endtask

  task automatic check_stats(input string tag);
`ifdef AXI_RB_RESPONDER_STATS_EN
    check({tag, "_beats"}, stat_beats, 32'(exp_beats));
    check({tag, "_bursts"}, stat_bursts, 32'(exp_bursts));
`else
    check({tag, "_beats_off"}, stat_beats, 32'd0);
    check({tag, "_bursts_off"}, stat_bursts, 32'd0);
`endif
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'h1000 + 32'(i);
    s_axi.araddr  = '0;
    s_axi.arburst = 2'd1;
    s_axi.arlen   = '0;
    s_axi.arsize  = 3'd2;
    s_axi.arvalid = 1'b0;
    s_axi.rready  = 1'b0;
    #1;
    check("reset_arready", {31'd0, s_axi.arready}, 32'd1);
    check("reset_rvalid", {31'd0, s_axi.rvalid}, 32'd0);
    check("reset_rlast", {31'd0, s_axi.rlast}, 32'd0);
    check("reset_rresp", {30'd0, s_axi.rresp}, 32'd0);
    check("reset_rdata", s_axi.rdata, 32'd0);
    check("reset_mem_ren", {31'd0, mem_ren}, 32'd0);
    check("reset_mem_raddr", {24'd0, mem_raddr}, 32'd0);
    check_stats("reset_stat");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_burst(16'h0010, 1, 3, 2, 0, 1'b0, -1, 0, -1);
    check("incr_first_word", exp_data[0], 32'h1004);
    run_burst(16'h0018, 2, 3, 2, 0, 1'b0, -1, 0, -1);
    run_burst(16'h0018, 2, 2, 2, 0, 1'b0, -1, 0, -1);
    run_burst(16'h0008, 0, 2, 2, 0, 1'b0, -1, 0, -1);
    run_burst(16'h0000, 1, 1, 3, 0, 1'b0, -1, 0, -1);
    run_burst(16'h0040, 1, 1, 2, 0, 1'b0, 1, 5, -1);
    run_burst(16'h03FC, 1, 1, 2, 0, 1'b0, -1, 0, -1);
    run_burst(16'h0000, 1, 255, 2, 0, 1'b0, -1, 0, -1);
    run_burst(16'h0020, 1, 7, 2, 0, 1'b0, -1, 0, 2);
    run_burst(16'h0100, 1, 3, 2, 0, 1'b0, -1, 0, -1);
    run_burst(16'h0200, 1, 3, 2, 0, 1'b0, -1, 0, -1);
    check_stats("two_bursts_stat");

    for (int n = 0; n < 40; n++) begin
      int addr;
      int burst;
      int len;
      int size;
      burst = $urandom_range(0, 3);
      size  = $urandom_range(0, 3);
      len   = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 15);
      addr  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 1100);
      if (burst == 2 && $urandom_range(0, 1) == 1) addr = addr & ~((1 << size) - 1);
      run_burst(addr, burst, len, size, 30, 1'($urandom_range(0, 1)), -1, 0, -1);
    end
    check_stats("final_stat");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, %0d checks so far", n_chk);
    $fatal(1);
  end
endmodule
